// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin system bus arbiter with release dead cycle
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int MSEL_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   bdone,
  input  logic [NUM_SLAVES-1:0]  sready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic                   bbusy,
  output logic                   tout
);

  typedef enum logic [1:0] {IDLE, BUSY, REL} state_t;

  state_t                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [MSEL_W-1:0]        msel_q, msel_d;
  logic [MSEL_W-1:0]        last_q, last_d;
  logic [MSEL_W-1:0]        pick;
  logic [MSEL_W:0]          cand;
  logic                     found;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;
`endif

  // Scan last+1, last+2, ... wrapping; the extra cand bit keeps the wrap a single subtract.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, last_q} + (MSEL_W+1)'(k);
      if (cand >= (MSEL_W+1)'(NUM_MASTERS))
        cand = cand - (MSEL_W+1)'(NUM_MASTERS);
      if (!found && breq[cand[MSEL_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[MSEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    msel_d  = msel_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found && (&sready)) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          msel_d        = pick;
          last_d        = pick;
          state_d       = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      BUSY: begin
        if (bdone || !breq[msel_q]) begin
          grant_d = '0;
          state_d = REL;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          grant_d = '0;
          state_d = REL;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      REL:     state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      msel_q  <= '0;
      last_q  <= MSEL_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      msel_q  <= msel_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign tout = tout_q;
`else
  assign tout = 1'b0;
`endif

  assign bgrant = grant_q;
  assign msel   = msel_q;
  assign bbusy  = |grant_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - directed and random checks of rr_bus_arbiter against a transaction-level model
module tb_rr_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 3;
`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 8;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 256;
  localparam bit TO_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] breq;
  logic          bdone;
  logic [NS-1:0] sready;
  logic [NM-1:0] bgrant;
  logic [0:0]    msel;
  logic          bbusy;
  logic          tout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 = nobody), whether the dead cycle is pending, rotation pointer.
  int m_owner, m_ptr, m_msel, m_held;
  bit m_dead, m_tout;

  rr_bus_arbiter #(
    .NUM_MASTERS(NM),
    .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .breq(breq),
    .bdone(bdone),
    .sready(sready),
    .bgrant(bgrant),
    .msel(msel),
    .bbusy(bbusy),
    .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    m_tout = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_dead  = 1'b0;
      m_ptr   = NM - 1;
      m_msel  = 0;
      m_held  = 0;
    end else if (m_owner >= 0) begin
      if (bdone || !breq[m_owner]) begin
        m_owner = -1;
        m_dead  = 1'b1;
      end else if (TO_EN && m_held == TO_CYC) begin
        m_owner = -1;
        m_dead  = 1'b1;
        m_tout  = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (breq != '0 && sready == '1) begin
      for (int k = 1; k <= NM; k++) begin
        if (m_owner < 0 && breq[(m_ptr + k) % NM])
          m_owner = (m_ptr + k) % NM;
      end
      m_ptr  = m_owner;
      m_msel = m_owner;
      m_held = 1;
    end
  endtask

  task automatic cyc();
    int eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("bgrant", int'(bgrant), eg);
    check("msel", int'(msel), m_msel);
    check("bbusy", int'(bbusy), (m_owner >= 0) ? 1 : 0);
    check("tout", int'(tout), int'(m_tout));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int gc;
    rst    = 1'b1;
    breq   = 2'b11;
    bdone  = 1'b0;
    sready = 3'b111;

    // Reset with requests pending, then first grant goes to master 0.
    cycles(3);
    check("rst_bgrant", int'(bgrant), 0);
    rst = 1'b0;
    cyc();
    check("first_grant", int'(bgrant), 1);
    check("first_msel", int'(msel), 0);

    // Both requesting, done pulse on each 4th grant cycle.
    gc = 1;
    for (int i = 0; i < 40; i++) begin
      bdone = (m_owner >= 0 && gc == 4);
      cyc();
      gc = (m_owner >= 0) ? gc + 1 : 0;
    end
    bdone = 1'b0;
    breq  = 2'b00;
    cycles(3);

    // Slave not ready blocks a lone request.
    breq   = 2'b10;
    sready = 3'b101;
    cycles(4);
    check("sready_block", int'(bgrant), 0);
    sready = 3'b111;
    cyc();
    check("sready_grant", int'(bgrant), 2);
    check("sready_msel", int'(msel), 1);
    breq = 2'b00;
    cycles(3);

    // Mid-transaction request and sready drop are ignored.
    breq = 2'b01;
    cyc();
    check("m0_grant", int'(bgrant), 1);
    breq = 2'b11;
    cycles(2);
    sready = 3'b011;
    cycles(2);
    check("hold_grant", int'(bgrant), 1);
    bdone = 1'b1;
    cyc();
    check("rel_cycle", int'(bgrant), 0);
    bdone = 1'b0;
    cycles(3);
    check("wait_sready", int'(bgrant), 0);
    sready = 3'b111;
    cyc();
    check("m1_after_rel", int'(bgrant), 2);
    check("m1_msel", int'(msel), 1);

    // Master abort by dropping its request.
    bdone = 1'b1;
    cyc();
    bdone = 1'b0;
    cycles(2);
    check("m0_again", int'(bgrant), 1);
    cycles(2);
    breq = 2'b10;
    cyc();
    check("abort_grant", int'(bgrant), 0);
    check("abort_busy", int'(bbusy), 0);
    cyc();
    check("abort_rel", int'(bgrant), 0);
    cyc();
    check("abort_next", int'(bgrant), 2);

    // Long hold without done: watchdog release, or indefinite hold.
    bdone = 1'b1;
    cyc();
    bdone = 1'b0;
    breq  = 2'b11;
    cycles(2);
    check("long_start", int'(bgrant), 1);
    cycles(120);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < NM; m++) begin
        if (breq[m]) breq[m] = ($urandom_range(0, 15) != 0);
        else         breq[m] = ($urandom_range(0, 3) == 0);
      end
      bdone = ($urandom_range(0, 4) == 0);
      for (int s = 0; s < NS; s++) sready[s] = ($urandom_range(0, 7) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
